// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared FSM encoding, prescale limits and parity helper for the UART RX frame engine
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  localparam int MIN_PRESCALE         = 4;
  localparam int DEFAULT_MAX_PRESCALE = 32;

  // Expected parity bit for up to 9 data bits; odd=1 selects odd parity.
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - per-bit edge counter with three-sample majority vote around mid-bit
module uart_rx_sampler #(
  parameter int MAX_PRESCALE = 32,
  parameter int PS_W         = $clog2(MAX_PRESCALE) + 1,
  parameter int CNT_W        = $clog2(MAX_PRESCALE)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            rx,
  input  logic            run,
  input  logic [PS_W-1:0] ps,
  output logic            bit_val,
  output logic            bit_done,
  output logic            sample_done
);

  logic [CNT_W-1:0] cnt;
  logic [PS_W-1:0]  cnt_x;
  logic [PS_W-1:0]  half;
  logic             s0;
  logic             s1;
  logic             bit_q;
  logic             maj;

  assign cnt_x       = PS_W'(cnt);
  assign half        = ps >> 1;
  assign maj         = (s0 & s1) | (s0 & rx) | (s1 & rx);
  assign bit_done    = run && (cnt_x == ps - 1'b1);
  assign sample_done = run && (cnt_x == half + 1'b1);
  // At the smallest prescale the vote and the bit end coincide, so forward the fresh vote.
  assign bit_val     = sample_done ? maj : bit_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt   <= '0;
      s0    <= 1'b1;
      s1    <= 1'b1;
      bit_q <= 1'b1;
    end else if (!run) begin
      cnt <= '0;
    end else begin
      cnt <= bit_done ? '0 : cnt + 1'b1;
      if (cnt_x == half - 1'b1) s0 <= rx;
      if (cnt_x == half) s1 <= rx;
      if (sample_done) bit_q <= maj;
    end
  end

endmodule

// File: rtl/uart_rx_frame_engine.sv
// rtl/uart_rx_frame_engine.sv - parametrised UART receiver FSM; UART_RX_BREAK_DET_EN adds break detection
module uart_rx_frame_engine
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_PRESCALE = DEFAULT_MAX_PRESCALE,
  parameter int PS_W         = $clog2(MAX_PRESCALE) + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PS_W-1:0]       Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
`ifdef UART_RX_BREAK_DET_EN
  output logic                  brk_det,
`endif
  output logic                  busy
);

  state_t                state;
  logic [PS_W-1:0]       ps_q;
  logic [PS_W-1:0]       ps_clamp;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  stop2_q;
  logic [DATA_WIDTH-1:0] shreg;
  logic [3:0]            bit_cnt;
  logic                  par_flag;
  logic                  stp_flag;
  logic                  sample_seen;
  logic                  run;
  logic                  bit_val;
  logic                  bit_done;
  logic                  sample_done;
  logic                  stp_now;
  logic                  last_stop;
`ifdef UART_RX_BREAK_DET_EN
  logic                  zero_run;
  logic [PS_W-1:0]       brk_cnt;
`endif

  always_comb begin
    ps_clamp = Prescale;
    if (Prescale < PS_W'(MIN_PRESCALE)) ps_clamp = PS_W'(MIN_PRESCALE);
    else if (Prescale > PS_W'(MAX_PRESCALE)) ps_clamp = PS_W'(MAX_PRESCALE);
  end

  assign run       = (state != IDLE) && (state != BREAK);
  assign stp_now   = stp_flag | ~bit_val;
  assign last_stop = !stop2_q || bit_cnt[0];

  uart_rx_sampler #(
    .MAX_PRESCALE(MAX_PRESCALE),
    .PS_W        (PS_W)
  ) u_sampler (
    .CLK        (CLK),
    .RST        (RST),
    .rx         (RX_IN),
    .run        (run),
    .ps         (ps_q),
    .bit_val    (bit_val),
    .bit_done   (bit_done),
    .sample_done(sample_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      ps_q        <= PS_W'(MIN_PRESCALE);
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      stop2_q     <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      par_flag    <= 1'b0;
      stp_flag    <= 1'b0;
      sample_seen <= 1'b0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      busy        <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brk_det     <= 1'b0;
      zero_run    <= 1'b0;
      brk_cnt     <= '0;
`endif
    end else begin
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      sample_seen <= sample_done;
`ifdef UART_RX_BREAK_DET_EN
      brk_det     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!RX_IN) begin
            state     <= START;
            busy      <= 1'b1;
            ps_q      <= ps_clamp;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            stop2_q   <= STOP2;
            bit_cnt   <= '0;
            par_flag  <= 1'b0;
            stp_flag  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            zero_run  <= 1'b1;
`endif
          end
        end
        START: begin
          // A start bit that votes high was a line glitch: drop it silently.
          if (sample_seen && bit_val) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (bit_done) begin
            if (bit_val) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (bit_done) begin
            shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
`ifdef UART_RX_BREAK_DET_EN
            zero_run <= zero_run & ~bit_val;
`endif
            if (bit_cnt == 4'(DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            par_flag <= (bit_val != parity_bit(9'(shreg), par_typ_q));
`ifdef UART_RX_BREAK_DET_EN
            zero_run <= zero_run & ~bit_val;
`endif
            state    <= STOP;
          end
        end
        STOP: begin
          if (bit_done) begin
`ifdef UART_RX_BREAK_DET_EN
            if (bit_cnt == 4'd0 && zero_run && !bit_val) begin
              brk_det <= 1'b1;
              brk_cnt <= '0;
              state   <= BREAK;
            end else
`endif
            if (last_stop) begin
              state <= IDLE;
              busy  <= 1'b0;
              if (!stp_now && !par_flag) begin
                P_DATA     <= shreg;
                data_valid <= 1'b1;
              end else begin
                par_err <= par_flag;
                stp_err <= stp_now;
              end
            end else begin
              stp_flag <= stp_now;
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_BREAK_DET_EN
        BREAK: begin
          // Wait for a full bit time of continuous idle before rearming.
          if (RX_IN) begin
            if (brk_cnt == ps_q - 1'b1) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              brk_cnt <= brk_cnt + 1'b1;
            end
          end else begin
            brk_cnt <= '0;
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_engine.sv
// tb/tb_uart_rx_frame_engine.sv - scoreboard bench for uart_rx_frame_engine (UART_RX_BREAK_DET_EN aware)
module tb_uart_rx_frame_engine;

  logic       CLK      = 1'b0;
  logic       RST      = 1'b0;
  logic       RX_IN    = 1'b1;
  logic [5:0] Prescale = 6'd32;
  logic       PAR_EN   = 1'b0;
  logic       PAR_TYP  = 1'b0;
  logic       STOP2    = 1'b0;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       busy;
  logic       brk_det;

  typedef struct packed {
    logic       v;
    logic       p;
    logic       s;
    logic       b;
    logic [7:0] d;
  } ev_t;

  ev_t exp_q[$];
  int  checks    = 0;
  int  fails     = 0;
  int  busy_len  = 0;
  int  last_busy = 0;

  always #5 CLK = ~CLK;

  uart_rx_frame_engine #(
    .DATA_WIDTH  (8),
    .MAX_PRESCALE(32)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .Prescale  (Prescale),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .STOP2     (STOP2),
    .P_DATA    (P_DATA),
    .data_valid(data_valid),
    .par_err   (par_err),
    .stp_err   (stp_err),
`ifdef UART_RX_BREAK_DET_EN
    .brk_det   (brk_det),
`endif
    .busy      (busy)
  );

`ifndef UART_RX_BREAK_DET_EN
  assign brk_det = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic v, input logic p, input logic s, input logic b,
                           input logic [7:0] d);
    exp_q.push_back(ev_t'({v, p, s, b, d}));
  endtask

  task automatic send_bit(input logic v, input int n);
    RX_IN = v;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_frame(input int n, input logic [7:0] d, input bit par, input logic pbit,
                            input logic [1:0] stops, input int nstop);
    send_bit(1'b0, n);
    for (int i = 0; i < 8; i++) send_bit(d[i], n);
    if (par) send_bit(pbit, n);
    for (int i = 0; i < nstop; i++) send_bit(stops[i], n);
  endtask

  // Scoreboard monitor: every output pulse must match the oldest pending expectation.
  always @(negedge CLK) begin
    ev_t e;
    if (data_valid || par_err || stp_err || brk_det) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'({data_valid, par_err, stp_err, brk_det}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("event_flags", 32'({data_valid, par_err, stp_err, brk_det}),
              32'({e.v, e.p, e.s, e.b}));
        check("p_data", 32'(P_DATA), 32'(e.d));
      end
    end
  end

  always @(negedge CLK) begin
    if (busy) begin
      busy_len++;
    end else if (busy_len != 0) begin
      last_busy = busy_len;
      busy_len  = 0;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_p_data", 32'(P_DATA), 32'd0);
    check("reset_outputs", 32'({data_valid, par_err, stp_err, busy, brk_det}), 32'd0);
    RST = 1'b1;
    send_bit(1'b1, 5);

    // Basic 8N1 frame at prescale 32
    Prescale = 6'd32;
    expect_ev(1, 0, 0, 0, 8'h55);
    send_frame(32, 8'h55, 0, 1'b0, 2'b01, 1);
    send_bit(1'b1, 10);
    check("busy_len_basic", 32'(last_busy), 32'd320);
    check("drained_basic", 32'(exp_q.size()), 32'd0);

    // Even parity, 0xA5 has four ones so parity bit should be 0; send 1
    Prescale = 6'd16;
    PAR_EN   = 1'b1;
    PAR_TYP  = 1'b0;
    expect_ev(0, 1, 0, 0, 8'h55);
    send_frame(16, 8'hA5, 1, 1'b1, 2'b01, 1);
    send_bit(1'b1, 8);
    check("drained_parity", 32'(exp_q.size()), 32'd0);

    // Two stop bits, second one low, then an immediate good frame
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    STOP2    = 1'b1;
    expect_ev(0, 0, 1, 0, 8'h55);
    send_frame(8, 8'h3C, 0, 1'b0, 2'b01, 2);
    expect_ev(1, 0, 0, 0, 8'h3C);
    send_frame(8, 8'h3C, 0, 1'b0, 2'b11, 2);
    send_bit(1'b1, 8);
    check("drained_stop", 32'(exp_q.size()), 32'd0);

    // Short start glitch must be ignored
    Prescale = 6'd32;
    STOP2    = 1'b0;
    send_bit(1'b0, 3);
    send_bit(1'b1, 100);
    check("glitch_busy", 32'(busy), 32'd0);
    expect_ev(1, 0, 0, 0, 8'hF0);
    send_frame(32, 8'hF0, 0, 1'b0, 2'b01, 1);
    send_bit(1'b1, 10);
    check("drained_glitch", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of the data bits of 0x81
    send_bit(1'b0, 32);
    send_bit(1'b1, 32);
    send_bit(1'b0, 32);
    send_bit(1'b0, 32);
    RST   = 1'b0;
    RX_IN = 1'b1;
    repeat (4) @(negedge CLK);
    check("abort_p_data", 32'(P_DATA), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    RST = 1'b1;
    send_bit(1'b1, 5);

    // Prescale port changes mid-frame; latched value must stay in use
    Prescale = 6'd16;
    expect_ev(1, 0, 0, 0, 8'h81);
    begin
      logic [7:0] d;
      d = 8'h81;
      send_bit(1'b0, 16);
      for (int i = 0; i < 4; i++) send_bit(d[i], 16);
      Prescale = 6'd8;
      for (int i = 4; i < 8; i++) send_bit(d[i], 16);
      send_bit(1'b1, 16);
    end
    send_bit(1'b1, 8);
    check("drained_ps_change", 32'(exp_q.size()), 32'd0);

    // Prescale below minimum clamps to 4; odd parity on 0x96 (four ones) is 1
    Prescale = 6'd2;
    PAR_EN   = 1'b1;
    PAR_TYP  = 1'b1;
    STOP2    = 1'b1;
    expect_ev(1, 0, 0, 0, 8'h96);
    send_frame(4, 8'h96, 1, 1'b1, 2'b11, 2);
    send_bit(1'b1, 8);
    check("busy_len_clamp_lo", 32'(last_busy), 32'd48);
    check("drained_clamp_lo", 32'(exp_q.size()), 32'd0);

    // Prescale above maximum clamps to 32
    Prescale = 6'd63;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    STOP2    = 1'b0;
    expect_ev(1, 0, 0, 0, 8'h0F);
    send_frame(32, 8'h0F, 0, 1'b0, 2'b01, 1);
    send_bit(1'b1, 10);
    check("busy_len_clamp_hi", 32'(last_busy), 32'd320);
    check("drained_clamp_hi", 32'(exp_q.size()), 32'd0);

    // All-zero frame with the stop bit held low for 40 cycles
    Prescale = 6'd32;
`ifdef UART_RX_BREAK_DET_EN
    expect_ev(0, 0, 0, 1, 8'h0F);
`else
    expect_ev(0, 0, 1, 0, 8'h0F);
`endif
    send_bit(1'b0, 32 * 9 + 40);
    RX_IN = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
    repeat (31) @(negedge CLK);
    check("break_hold_busy", 32'(busy), 32'd1);
    @(negedge CLK);
    check("break_release_busy", 32'(busy), 32'd0);
`endif
    send_bit(1'b1, 100);
    check("final_busy", 32'(busy), 32'd0);
    check("drained_final", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_engine.md
Name: uart_rx_frame_engine

Overview:
Parametrised successor to the fixed 8-bit, prescale-32 UART receiver inside the system top. It runs in the UART clock domain and converts the serial RX_IN line into DATA_WIDTH-bit parallel words. New capabilities:
- prescale selectable at run time
- optional parity (even or odd)
- 1 or 2 stop bits
- 3-sample majority vote
- start-glitch rejection
- separate parity and stop error pulses

Its output feeds the system controller's command decoder.

Parameters:
- DATA_WIDTH, 8, payload bits per frame (legal range 5..9).
- MAX_PRESCALE, 32, largest oversampling ratio supported. Sets the edge-counter width to $clog2(MAX_PRESCALE).
- PS_W, $clog2(MAX_PRESCALE)+1, width of the Prescale port.

Ports:
- CLK  in  1  UART oversampling clock.
- RST  in  1  asynchronous reset, active low.
- RX_IN  in  1  serial line; idles high.
- Prescale  in  PS_W  oversampling ratio, sampled at start-bit detection.
- PAR_EN  in  1  parity bit present.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- STOP2  in  1  two stop bits when 1.
- P_DATA  out  DATA_WIDTH  received word, LSB first on the line.
- data_valid  out  1  one-cycle pulse: a good frame is in P_DATA.
- par_err  out  1  one-cycle pulse: parity mismatch.
- stp_err  out  1  one-cycle pulse: a stop bit sampled 0.
- busy  out  1  high from start-bit detection until return to IDLE.

Behaviour:
- Clock and reset (already decided): one clock, CLK; reset RST is asynchronous and active-low.
- Reset: all outputs are 0, the FSM goes to IDLE and all counters clear. An assertion mid-frame aborts the frame with no pulse on any output.
- Effective prescale PS:
  - Prescale is clamped to the range 4..MAX_PRESCALE.
  - PS is latched into a register on IDLE→START.
  - Changes to Prescale during a frame are ignored.
- Sampling:
  - The edge counter runs 0..PS-1 within each bit.
  - Samples are taken at edge counts PS/2-1, PS/2 and PS/2+1 (integer division).
  - The bit value is the majority of the three samples, registered at edge count PS/2+1.
- FSM transitions:
  - IDLE → START when RX_IN is 0 (start of the falling edge); edge count resets to 0.
  - START: if the majority value is 1, this is a glitch; return to IDLE at PS/2+2 with no outputs. Otherwise go to DATA at edge count PS-1.
  - DATA: shift in DATA_WIDTH bits, LSB first. Go to PARITY if PAR_EN, else STOP.
  - PARITY: compare the received bit with the XOR-reduction of the data (inverted when PAR_TYP=1). A mismatch sets an internal par_flag.
  - STOP: 1 or 2 bits. Any stop bit sampled 0 sets stp_flag.
- End of frame, at edge count PS-1 of the last stop bit:
  - The FSM returns to IDLE.
  - P_DATA is updated only when both flags are clear.
  - Exactly one cycle of: data_valid if no flags; otherwise par_err and/or stp_err, which may be simultaneous.
- Back-to-back frames: IDLE may detect a new start bit on the cycle after the frame ends. Zero idle gap is legal.
- busy drops in the same cycle as the end-of-frame pulse.
- P_DATA holds its value until the next good frame.
- PAR_EN, PAR_TYP and STOP2 are latched together with Prescale.

Optional Feature:
- Macro: UART_RX_BREAK_DET_EN.
- With the macro defined:
  - Adds output brk_det (1 bit).
  - A frame whose data bits, parity bit and first stop bit all sample 0 raises brk_det for one cycle instead of stp_err/par_err.
  - The FSM then enters a BREAK state and waits until RX_IN has been 1 for PS consecutive cycles before returning to IDLE.
- Without the macro: the same line condition reports stp_err (plus par_err if applicable) and returns to IDLE normally.

Decomposition:
- Package uart_rx_pkg contains:
  - the state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - the constants MIN_PRESCALE=4 and the default MAX_PRESCALE;
  - a parity function.
- Sub-module uart_rx_sampler contains the edge counter, the three-sample capture and the majority vote. Its outputs are bit_val, bit_done (at PS-1) and sample_done (at PS/2+1).
- The top level holds the FSM, shift register, bit counter and flags.

Test Plan:
- Basic frame: Prescale=32, PAR_EN=0, send 0x55 → exactly one data_valid, P_DATA=0x55, busy high for 10×32 cycles.
- Parity error: Prescale=16, PAR_EN=1, PAR_TYP=0 (even), send 0xA5 with parity bit 1 → par_err pulse, no data_valid, P_DATA unchanged.
- Stop error: Prescale=8, STOP2=1, send 0x3C with the second stop bit 0 → stp_err pulse, next frame 0x3C with zero gap → data_valid, P_DATA=0x3C.
- Start glitch: RX_IN low for 3 cycles at Prescale=32 → no outputs, busy returns to 0, then valid 0xF0 → data_valid, P_DATA=0xF0.
- Reset and prescale change: RST pulse low mid-data of 0x81 → no pulses; Prescale changed mid-frame of 0x81 → still received correctly.
- Break (macro defined): 0x00 frame with stop bit 0 held 40 cycles → brk_det pulse, no stp_err, FSM returns to IDLE only after 32 high cycles.
